ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder.sv | 85 ++++++++
 tb/tb_ripple_carry_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - registered A +/- (B >>> shamt) with explicit ripple-carry chain
module ripple_carry_adder #(
  parameter int NO_BITS = 12,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [NO_BITS-1:0] a,
  input  logic [NO_BITS-1:0] b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sub,
  output logic               out_valid,
  output logic [NO_BITS-1:0] sum,
  output logic               cout,
  output logic               ovf
);

  localparam int MSB = NO_BITS - 1;

  // Barrel shifter: stage[k] holds B after the first k shift stages.
  logic [SHAMT_W:0][NO_BITS-1:0] stage;
  logic [NO_BITS-1:0]            b_shifted;
  logic [NO_BITS-1:0]            e_op;
  logic [NO_BITS-1:0]            s_comb;
  logic [NO_BITS:0]              c_chain;
  logic                          ovf_comb;

  assign stage[0] = b;

  // Stage k shifts by 2^k when shamt[k] is set; bits shifted in past the
  // top copy the sign bit, so any shift >= NO_BITS collapses to 0 or all-ones.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int SH = (k >= 30) ? NO_BITS : (1 << k);
    for (genvar i = 0; i < NO_BITS; i++) begin : g_bit
      if (i + SH < NO_BITS) begin : g_in
        assign stage[k+1][i] = shamt[k] ? stage[k][i+SH] : stage[k][i];
      end else begin : g_fill
        assign stage[k+1][i] = shamt[k] ? stage[k][MSB] : stage[k][i];
      end
    end
  end

  assign b_shifted = stage[SHAMT_W];

  // Subtraction is A + ~B' + 1: invert the operand and feed sub in as carry-in.
  assign e_op = b_shifted ^ {NO_BITS{sub}};

  // Explicit full-adder chain, LSB first, so the carry path is visible to timing.
  always_comb begin
    s_comb     = '0;
    c_chain    = '0;
    c_chain[0] = sub;
    for (int i = 0; i < NO_BITS; i++) begin
      s_comb[i]    = a[i] ^ e_op[i] ^ c_chain[i];
      c_chain[i+1] = (a[i] & e_op[i]) | (c_chain[i] & (a[i] ^ e_op[i]));
    end
  end

  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_comb = (a[MSB] == e_op[MSB]) && (s_comb[MSB] != a[MSB]);

  // out_valid tracks in_valid every cycle, regardless of operand enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result registers load only on valid operands and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (in_valid) begin
      sum  <= s_comb;
      cout <= c_chain[NO_BITS];
      ovf  <= ovf_comb;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb/tb_ripple_carry_adder.sv - self-checking bench for ripple_carry_adder (16-bit and 12-bit)
module tb_ripple_carry_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit X/Y style instance
  logic        iv16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  sh16 = '0;
  logic        v16, c16, o16;
  logic [15:0] s16;

  // 12-bit Z style instance
  logic        iv12 = 1'b0, sub12 = 1'b0;
  logic [11:0] a12 = '0, b12 = '0;
  logic [3:0]  sh12 = '0;
  logic        v12, c12, o12;
  logic [11:0] s12;

  ripple_carry_adder #(.NO_BITS(16), .SHAMT_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16), .shamt(sh16),
    .sub(sub16), .out_valid(v16), .sum(s16), .cout(c16), .ovf(o16)
  );

  ripple_carry_adder #(.NO_BITS(12), .SHAMT_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv12), .a(a12), .b(b12), .shamt(sh12),
    .sub(sub12), .out_valid(v12), .sum(s12), .cout(c12), .ovf(o12)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the shifted operand.
  function automatic void model(input int n, input int ua, input int ub, input int sh,
                                input bit sb, output int rsum, output bit rcout,
                                output bit rovf);
    int mask;
    int half;
    int sa;
    int bsh;
    int ubs;
    int uaa;
    int r;
    mask = (1 << n) - 1;
    half = 1 << (n - 1);
    uaa  = ua & mask;
    sa   = (uaa ^ half) - half;
    bsh  = (((ub & mask) ^ half) - half) >>> sh;
    ubs  = bsh & mask;
    r    = sb ? (sa - bsh) : (sa + bsh);
    rsum = r & mask;
    rovf = (r >= half) || (r < -half);
    rcout = sb ? (uaa >= ubs) : ((uaa + ubs) > mask);
  endfunction

  logic [15:0] es16; logic ev16, ec16, eo16;
  logic [11:0] es12; logic ev12, ec12, eo12;

  // Expected register state for the 16-bit instance
  always @(posedge clk or negedge rst_n) begin : m16
    int  t_s;
    bit  t_c, t_o;
    if (!rst_n) begin
      es16 <= '0; ev16 <= 1'b0; ec16 <= 1'b0; eo16 <= 1'b0;
    end else begin
      ev16 <= iv16;
      if (iv16) begin
        model(16, int'(a16), int'(b16), int'(sh16), sub16, t_s, t_c, t_o);
        es16 <= t_s[15:0]; ec16 <= t_c; eo16 <= t_o;
      end
    end
  end

  // Expected register state for the 12-bit instance
  always @(posedge clk or negedge rst_n) begin : m12
    int  t_s;
    bit  t_c, t_o;
    if (!rst_n) begin
      es12 <= '0; ev12 <= 1'b0; ec12 <= 1'b0; eo12 <= 1'b0;
    end else begin
      ev12 <= iv12;
      if (iv12) begin
        model(12, int'(a12), int'(b12), int'(sh12), sub12, t_s, t_c, t_o);
        es12 <= t_s[11:0]; ec12 <= t_c; eo12 <= t_o;
      end
    end
  end

  // Every-cycle comparison away from the active edge
  always @(negedge clk) begin
    check("m16_valid", 32'(v16), 32'(ev16));
    check("m16_sum",   32'(s16), 32'(es16));
    check("m16_cout",  32'(c16), 32'(ec16));
    check("m16_ovf",   32'(o16), 32'(eo16));
    check("m12_valid", 32'(v12), 32'(ev12));
    check("m12_sum",   32'(s12), 32'(es12));
    check("m12_cout",  32'(c12), 32'(ec12));
    check("m12_ovf",   32'(o12), 32'(eo12));
  end

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh,
                      input logic s);
    a16 = a; b16 = b; sh16 = sh; sub16 = s; iv16 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic op12(input logic [11:0] a, input logic [11:0] b, input logic [3:0] sh,
                      input logic s);
    a12 = a; b12 = b; sh12 = sh; sub12 = s; iv12 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic exp16(input string name, input logic [15:0] s, input logic c, input logic o);
    check({name, "_sum"},  32'(s16), 32'(s));
    check({name, "_cout"}, 32'(c16), 32'(c));
    check({name, "_ovf"},  32'(o16), 32'(o));
    check({name, "_vld"},  32'(v16), 32'd1);
  endtask

  initial begin
    int  p_s;
    bit  p_c, p_o;
    logic [15:0] edge16 [4];
    edge16[0] = 16'h7FFF; edge16[1] = 16'h8000; edge16[2] = 16'hFFFF; edge16[3] = 16'h0000;

    // Pin the reference model on hand-computed values
    model(16, 'h26DE, 'h26DE, 1, 1'b0, p_s, p_c, p_o);
    check("pin_cordic", 32'(p_s), 32'h3A4D);
    model(16, 'h0005, 'h0007, 0, 1'b1, p_s, p_c, p_o);
    check("pin_borrow_sum", 32'(p_s), 32'hFFFE);
    check("pin_borrow_cout", 32'(p_c), 32'd0);
    model(16, 'h8000, 'h0001, 0, 1'b1, p_s, p_c, p_o);
    check("pin_ovf_sub", {p_s[15:0], 14'd0, p_c, p_o}, {16'h7FFF, 14'd0, 1'b1, 1'b1});
    model(12, 'h000, 'h324, 0, 1'b1, p_s, p_c, p_o);
    check("pin_z", 32'(p_s), 32'hCDC);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum16", 32'(s16), 32'd0);
    check("rst_vld16", 32'(v16), 32'd0);
    check("rst_sum12", 32'(s12), 32'd0);
    rst_n = 1'b1;

    // CORDIC X/Y steps and shifter boundaries
    op16(16'h26DE, 16'h0000, 4'd0, 1'b1);  exp16("xy_sub0",  16'h26DE, 1'b1, 1'b0);
    op16(16'h26DE, 16'h26DE, 4'd1, 1'b0);  exp16("xy_add1",  16'h3A4D, 1'b0, 1'b0);
    op16(16'h0000, 16'h8000, 4'd4, 1'b0);  exp16("sh4",      16'hF800, 1'b0, 1'b0);
    op16(16'h0000, 16'h8000, 4'd15, 1'b0); exp16("sh15_neg", 16'hFFFF, 1'b0, 1'b0);
    op16(16'h0000, 16'h4000, 4'd15, 1'b0); exp16("sh15_pos", 16'h0000, 1'b0, 1'b0);
    op16(16'h0005, 16'h0007, 4'd0, 1'b1);  exp16("borrow",   16'hFFFE, 1'b0, 1'b0);
    op16(16'h7FFF, 16'h0001, 4'd0, 1'b0);  exp16("ovf_add",  16'h8000, 1'b0, 1'b1);
    op16(16'h8000, 16'h0001, 4'd0, 1'b1);  exp16("ovf_sub",  16'h7FFF, 1'b1, 1'b1);
    iv16 = 1'b0;

    // Z path and hold
    op12(12'h000, 12'h324, 4'd0, 1'b1);
    check("z_sub", 32'(s12), 32'hCDC);
    op12(12'hCDC, 12'h1DA, 4'd0, 1'b0);
    check("z_add", 32'(s12), 32'hEB6);
    a12 = 12'h555; b12 = 12'h0AA; iv12 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_sum", 32'(s12), 32'hEB6);
      check("hold_vld", 32'(v12), 32'd0);
    end

    // Asynchronous reset mid-cycle after a nonzero result
    op16(16'h7FFF, 16'h0001, 4'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_sum",  32'(s16), 32'd0);
    check("arst_cout", 32'(c16), 32'd0);
    check("arst_ovf",  32'(o16), 32'd0);
    check("arst_vld",  32'(v16), 32'd0);
    check("arst_sum12", 32'(s12), 32'd0);
    @(posedge clk); #1;
    check("arst_held", 32'(s16), 32'd0);
    rst_n = 1'b1;
    op16(16'h26DE, 16'h26DE, 4'd1, 1'b0);  exp16("post_rst", 16'h3A4D, 1'b0, 1'b0);

    // Randomized traffic on both instances, with one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      iv16  = ($urandom_range(0, 3) != 0);
      a16   = ($urandom_range(0, 7) == 0) ? edge16[$urandom_range(0, 3)] : 16'($urandom);
      b16   = ($urandom_range(0, 7) == 0) ? edge16[$urandom_range(0, 3)] : 16'($urandom);
      sh16  = 4'($urandom);
      sub16 = 1'($urandom);
      iv12  = ($urandom_range(0, 3) != 0);
      a12   = 12'($urandom);
      b12   = 12'($urandom);
      sh12  = 4'($urandom);
      sub12 = 1'($urandom);
      if (i == 300) begin
        #2 rst_n = 1'b0;
      end
      if (i == 303) rst_n = 1'b1;
      @(posedge clk); #1;
    end

    iv16 = 1'b0; iv12 = 1'b0;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
